// File: rtl/f1_reaction_ctrl_if.sv
// f1_reaction_ctrl_if: signal bundle between the F1 start-light controller
// and its surroundings (tick generator, LFSR, LED/BCD display path).
//
// Signalling rules: there is no valid/ready handshake on this bundle.
// tick_ms is a one-clk strobe. trigger and react are levels, and only
// their rising edges act. result_valid is a one-clk strobe marking the
// clk in which react_ms carries a new value. All other outputs are levels.
// The master modport is the environment side. The slave modport is the
// controller side.
interface f1_reaction_ctrl_if;
    logic        tick_ms;
    logic        trigger;
    logic        react;
    logic [5:0]  lfsr_in;
    logic        lfsr_en;
    logic [9:0]  ledr;
    logic [13:0] react_ms;
    logic [13:0] best_ms;
    logic        result_valid;
    logic        false_start;
    logic [2:0]  phase;

    modport master (
        output tick_ms, trigger, react, lfsr_in,
        input  lfsr_en, ledr, react_ms, best_ms, result_valid, false_start, phase
    );

    modport slave (
        input  tick_ms, trigger, react, lfsr_in,
        output lfsr_en, ledr, react_ms, best_ms, result_valid, false_start, phase
    );
endinterface

// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: F1 start-light reaction game sequencer.
// The controller runs the five-step light build-up and then a hold of random
// length, taken from the LFSR. It then counts the driver's reaction time in
// ms and flags false starts. The phase output exposes the FSM state.
// Optional feature macro F1_BEST_TIME_EN: when it is defined, the block keeps
// a best-time record on best_ms. When it is undefined, best_ms is tied to
// SAT_MS.
module f1_reaction_ctrl #(
    parameter int STEP_MS       = 500,
    parameter int DELAY_UNIT_MS = 16,
    parameter int SAT_MS        = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    f1_reaction_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_HOLD   = 3'd2,
        S_TIMING = 3'd3,
        S_DONE   = 3'd4,
        S_FOUL   = 3'd5
    } state_t;

    localparam logic [9:0]  STEP_LAST = 10'(STEP_MS - 1);
    localparam logic [13:0] SAT_VAL   = 14'(SAT_MS);
    localparam logic [9:0]  FOUL_LEDS = 10'h155;
    localparam logic [9:0]  ALL_LEDS  = 10'h3FF;

    state_t      r_state, w_state_nxt;
    logic        r_trig_d, r_react_d;
    logic [9:0]  r_ms_cnt, w_ms_cnt_nxt;
    logic [2:0]  r_step, w_step_nxt;
    logic [9:0]  r_hold_ms, w_hold_ms_nxt;
    logic [13:0] r_react_cnt, w_react_cnt_nxt;
    logic [9:0]  r_ledr, w_ledr_nxt;
    logic [13:0] r_react_ms, w_react_ms_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_false, w_false_nxt;
    logic        r_lfsr_en, w_lfsr_en_nxt;
    logic        w_trig_rise, w_react_rise;
    logic [5:0]  w_lfsr_eff;
    logic [15:0] w_hold_prod;

    assign w_trig_rise  = bus.trigger & ~r_trig_d;
    assign w_react_rise = bus.react & ~r_react_d;
    // An LFSR value of zero would give a zero hold, so it counts as one unit.
    assign w_lfsr_eff   = (bus.lfsr_in == 6'd0) ? 6'd1 : bus.lfsr_in;
    assign w_hold_prod  = 16'(w_lfsr_eff) * 16'(DELAY_UNIT_MS);

    // Next-state and next-output logic; every register holds unless a rule below fires.
    always_comb begin
        w_state_nxt     = r_state;
        w_ms_cnt_nxt    = r_ms_cnt;
        w_step_nxt      = r_step;
        w_hold_ms_nxt   = r_hold_ms;
        w_react_cnt_nxt = r_react_cnt;
        w_ledr_nxt      = r_ledr;
        w_react_ms_nxt  = r_react_ms;
        w_valid_nxt     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (w_trig_rise) begin
                    w_state_nxt  = S_LIGHTS;
                    w_ms_cnt_nxt = 10'd0;
                    w_step_nxt   = 3'd0;
                    w_ledr_nxt   = 10'd0;
                end
            end
            S_LIGHTS: begin
                if (w_react_rise) begin
                    w_state_nxt = S_FOUL;
                    w_ledr_nxt  = FOUL_LEDS;
                end else if (bus.tick_ms) begin
                    if (r_ms_cnt == STEP_LAST) begin
                        w_ms_cnt_nxt = 10'd0;
                        w_step_nxt   = r_step + 3'd1;
                        w_ledr_nxt   = {r_ledr[7:0], 2'b11};
                        // The fifth step completes the build-up, so the hold length is latched here.
                        if (r_step == 3'd4) begin
                            w_hold_ms_nxt = w_hold_prod[9:0];
                            w_state_nxt   = S_HOLD;
                        end
                    end else begin
                        w_ms_cnt_nxt = r_ms_cnt + 10'd1;
                    end
                end
            end
            S_HOLD: begin
                // A react rise beats a tick that arrives in the same clk.
                if (w_react_rise) begin
                    w_state_nxt = S_FOUL;
                    w_ledr_nxt  = FOUL_LEDS;
                end else if (bus.tick_ms) begin
                    if (r_ms_cnt == r_hold_ms - 10'd1) begin
                        w_state_nxt     = S_TIMING;
                        w_ledr_nxt      = 10'd0;
                        w_react_cnt_nxt = 14'd0;
                        w_ms_cnt_nxt    = 10'd0;
                    end else begin
                        w_ms_cnt_nxt = r_ms_cnt + 10'd1;
                    end
                end
            end
            S_TIMING: begin
                // A react rise captures the count before any tick in the same clk is added.
                if (w_react_rise) begin
                    w_react_ms_nxt = r_react_cnt;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_DONE;
                end else if (bus.tick_ms && (r_react_cnt < SAT_VAL)) begin
                    w_react_cnt_nxt = r_react_cnt + 14'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ledr_nxt  = 10'd0;
            end
        endcase
        w_false_nxt   = (w_state_nxt == S_FOUL);
        w_lfsr_en_nxt = !((w_state_nxt == S_HOLD) || (w_state_nxt == S_TIMING));
    end

    // State, counters, edge-detect delays and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_trig_d    <= 1'b0;
            r_react_d   <= 1'b0;
            r_ms_cnt    <= 10'd0;
            r_step      <= 3'd0;
            r_hold_ms   <= 10'd0;
            r_react_cnt <= 14'd0;
            r_ledr      <= 10'd0;
            r_react_ms  <= 14'd0;
            r_valid     <= 1'b0;
            r_false     <= 1'b0;
            r_lfsr_en   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_trig_d    <= bus.trigger;
            r_react_d   <= bus.react;
            r_ms_cnt    <= w_ms_cnt_nxt;
            r_step      <= w_step_nxt;
            r_hold_ms   <= w_hold_ms_nxt;
            r_react_cnt <= w_react_cnt_nxt;
            r_ledr      <= w_ledr_nxt;
            r_react_ms  <= w_react_ms_nxt;
            r_valid     <= w_valid_nxt;
            r_false     <= w_false_nxt;
            r_lfsr_en   <= w_lfsr_en_nxt;
        end
    end

`ifdef F1_BEST_TIME_EN
    logic [13:0] r_best_ms;

    // Best-time record, updated in the same clk as the result_valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_ms <= SAT_VAL;
        end else if ((r_state == S_TIMING) && w_react_rise && (r_react_cnt < r_best_ms)) begin
            r_best_ms <= r_react_cnt;
        end
    end

    assign bus.best_ms = r_best_ms;
`else
    assign bus.best_ms = SAT_VAL;
`endif

    assign bus.phase        = r_state;
    assign bus.ledr         = r_ledr;
    assign bus.react_ms     = r_react_ms;
    assign bus.result_valid = r_valid;
    assign bus.false_start  = r_false;
    assign bus.lfsr_en      = r_lfsr_en;

endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// tb_f1_reaction_ctrl: bench for f1_reaction_ctrl, built with or without
// F1_BEST_TIME_EN. A behavioural model tracks the phase and the ms elapsed
// in it, and the expected outputs are derived from that every cycle.
module tb_f1_reaction_ctrl;

    localparam int STEP = 500;
    localparam int UNIT = 16;
    localparam int SAT  = 9999;
`ifdef F1_BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    f1_reaction_ctrl_if bus();

    f1_reaction_ctrl #(.STEP_MS(STEP), .DELAY_UNIT_MS(UNIT), .SAT_MS(SAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [13:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: the phase, the ms elapsed in it, and the results.
    int m_phase  = 0;
    int m_t      = 0;
    int m_hold   = 0;
    int m_react  = 0;
    int m_best   = SAT;
    bit m_valid  = 1'b0;
    bit m_trig_d = 1'b0;
    bit m_react_d = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit tr, rr;
        int lf;
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_hold = 0; m_react = 0; m_best = SAT;
            m_valid = 1'b0; m_trig_d = 1'b0; m_react_d = 1'b0;
            exp_q.delete();
        end else begin
            tr = bus.trigger && !m_trig_d;
            rr = bus.react && !m_react_d;
            m_trig_d  = bus.trigger;
            m_react_d = bus.react;
            m_valid   = 1'b0;
            case (m_phase)
                0, 4, 5: if (tr) begin m_phase = 1; m_t = 0; end
                1: begin
                    if (rr) m_phase = 5;
                    else if (bus.tick_ms) begin
                        m_t++;
                        if (m_t == 5 * STEP) begin
                            lf = (bus.lfsr_in == 6'd0) ? 1 : int'(bus.lfsr_in);
                            m_hold  = (lf * UNIT) % 1024;
                            m_phase = 2;
                            m_t     = 0;
                        end
                    end
                end
                2: begin
                    if (rr) m_phase = 5;
                    else if (bus.tick_ms) begin
                        m_t++;
                        if (m_t == m_hold) begin m_phase = 3; m_t = 0; end
                    end
                end
                3: begin
                    if (rr) begin
                        m_react = (m_t > SAT) ? SAT : m_t;
                        m_valid = 1'b1;
                        exp_q.push_back(14'(m_react));
                        if (BEST_EN && m_react < m_best) m_best = m_react;
                        m_phase = 4;
                    end else if (bus.tick_ms) m_t++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [9:0] exp_ledr();
        int n;
        case (m_phase)
            1: begin n = m_t / STEP; return 10'((1 << (2 * n)) - 1); end
            2: return 10'h3FF;
            5: return 10'h155;
            default: return 10'h000;
        endcase
    endfunction

    // Compare process: every cycle out of reset, plus the result scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("phase", 32'(bus.phase), 32'(m_phase));
            check("ledr", 32'(bus.ledr), 32'(exp_ledr()));
            check("lfsr_en", 32'(bus.lfsr_en), 32'(m_phase != 2 && m_phase != 3));
            check("false_start", 32'(bus.false_start), 32'(m_phase == 5));
            check("result_valid", 32'(bus.result_valid), 32'(m_valid));
            check("react_ms", 32'(bus.react_ms), 32'(m_react));
            check("best_ms", 32'(bus.best_ms), 32'(m_best));
            if (bus.result_valid) begin
                check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("sb_react", 32'(bus.react_ms), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 7) == 0) begin
                bus.tick_ms = 1'b0;
                cyc();
            end
            bus.tick_ms = 1'b1;
            if (rnd) bus.lfsr_in = 6'($urandom);
            cyc();
        end
        bus.tick_ms = 1'b0;
    endtask

    task automatic trig();
        bus.trigger = 1'b1;
        cyc();
        bus.trigger = 1'b0;
        cyc();
    endtask

    // Leaves the bench at the negedge right after the react rise was sampled.
    task automatic press(input bit with_tick);
        bus.react   = 1'b1;
        bus.tick_ms = with_tick;
        cyc();
        bus.react   = 1'b0;
        bus.tick_ms = 1'b0;
    endtask

    logic [9:0] lights_tab [5] = '{10'h003, 10'h00F, 10'h03F, 10'h0FF, 10'h3FF};
    int kind;

    initial begin
        bus.tick_ms = 1'b0; bus.trigger = 1'b0; bus.react = 1'b0; bus.lfsr_in = 6'd5;
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_ledr", 32'(bus.ledr), 32'd0);
        check("rst_best", 32'(bus.best_ms), 32'd9999);
        check("rst_lfsr_en", 32'(bus.lfsr_en), 32'd1);
        check("rst_react_ms", 32'(bus.react_ms), 32'd0);

        // Run 1: lfsr 5 -> 80 ms hold, react after 237 ms.
        trig();
        check("run1_lights_phase", 32'(bus.phase), 32'd1);
        for (int k = 0; k < 5; k++) begin
            ticks(STEP, 1'b0);
            check("run1_ledr_step", 32'(bus.ledr), 32'(lights_tab[k]));
        end
        check("run1_hold_phase", 32'(bus.phase), 32'd2);
        check("run1_hold_lfsr_en", 32'(bus.lfsr_en), 32'd0);
        ticks(79, 1'b0);
        check("run1_hold_79", 32'(bus.phase), 32'd2);
        ticks(1, 1'b0);
        check("run1_timing_phase", 32'(bus.phase), 32'd3);
        check("run1_timing_ledr", 32'(bus.ledr), 32'd0);
        trig();
        check("run1_trig_ignored", 32'(bus.phase), 32'd3);
        ticks(237, 1'b0);
        press(1'b0);
        check("run1_react_ms", 32'(bus.react_ms), 32'd237);
        check("run1_valid", 32'(bus.result_valid), 32'd1);
        check("run1_done", 32'(bus.phase), 32'd4);
        check("run1_best", 32'(bus.best_ms), BEST_EN ? 32'd237 : 32'd9999);
        cyc();
        check("run1_valid_single", 32'(bus.result_valid), 32'd0);

        // Run 2: slower reaction must not replace the best time.
        trig();
        ticks(5 * STEP + 80 + 300, 1'b0);
        press(1'b0);
        check("run2_react_ms", 32'(bus.react_ms), 32'd300);
        check("run2_best", 32'(bus.best_ms), BEST_EN ? 32'd237 : 32'd9999);

        // False start during light step 3, then restart and a saturated run.
        trig();
        ticks(1200, 1'b0);
        check("foul_pre_ledr", 32'(bus.ledr), 32'h00F);
        press(1'b0);
        check("foul_phase", 32'(bus.phase), 32'd5);
        check("foul_ledr", 32'(bus.ledr), 32'h155);
        check("foul_flag", 32'(bus.false_start), 32'd1);
        check("foul_react_kept", 32'(bus.react_ms), 32'd300);
        trig();
        check("foul_cleared", 32'(bus.false_start), 32'd0);
        check("foul_restart", 32'(bus.phase), 32'd1);
        ticks(STEP, 1'b0);
        check("foul_restart_ledr", 32'(bus.ledr), 32'h003);
        bus.lfsr_in = 6'd0;
        ticks(4 * STEP, 1'b0);
        check("zero_lfsr_hold", 32'(bus.phase), 32'd2);
        ticks(16, 1'b0);
        check("zero_lfsr_timing", 32'(bus.phase), 32'd3);
        ticks(12000, 1'b0);
        press(1'b0);
        check("sat_react_ms", 32'(bus.react_ms), 32'd9999);

        // Same-clk react and tick in TIMING captures the pre-increment count.
        bus.lfsr_in = 6'd2;
        trig();
        ticks(5 * STEP + 32 + 42, 1'b0);
        press(1'b1);
        check("same_clk_react_ms", 32'(bus.react_ms), 32'd42);

        // Same-clk react and final hold tick: the false start wins.
        bus.lfsr_in = 6'd1;
        trig();
        ticks(5 * STEP + 15, 1'b0);
        press(1'b1);
        check("final_tick_foul", 32'(bus.phase), 32'd5);
        check("final_tick_react_kept", 32'(bus.react_ms), 32'd42);

        // Randomized runs with tick gaps and a wandering LFSR.
        for (int r = 0; r < 6; r++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) press(1'b0);
            cyc();
            trig();
            case (kind)
                0: begin
                    ticks($urandom_range(1, 5 * STEP - 1), 1'b1);
                    press(1'($urandom_range(0, 1)));
                end
                1: begin
                    ticks(5 * STEP, 1'b1);
                    ticks($urandom_range(0, m_hold - 1), 1'b1);
                    press(1'($urandom_range(0, 1)));
                end
                default: begin
                    ticks(5 * STEP, 1'b1);
                    ticks(m_hold, 1'b1);
                    if ($urandom_range(0, 1) == 1) trig();
                    ticks($urandom_range(0, 400), 1'b1);
                    press(1'($urandom_range(0, 1)));
                end
            endcase
            ticks($urandom_range(0, 20), 1'b1);
        end

        // React in the first clk of TIMING yields zero.
        cyc();
        bus.lfsr_in = 6'd1;
        trig();
        ticks(5 * STEP + 16, 1'b0);
        check("first_clk_timing", 32'(bus.phase), 32'd3);
        press(1'b0);
        check("first_clk_react_ms", 32'(bus.react_ms), 32'd0);
        check("first_clk_valid", 32'(bus.result_valid), 32'd1);

        // Asynchronous reset in the middle of HOLD.
        bus.lfsr_in = 6'd5;
        cyc();
        trig();
        ticks(5 * STEP + 10, 1'b0);
        check("pre_reset_hold", 32'(bus.phase), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ledr", 32'(bus.ledr), 32'd0);
        check("async_rst_phase", 32'(bus.phase), 32'd0);
        check("async_rst_best", 32'(bus.best_ms), 32'd9999);
        check("async_rst_lfsr_en", 32'(bus.lfsr_en), 32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_idle", 32'(bus.phase), 32'd0);
        trig();
        check("post_rst_start", 32'(bus.phase), 32'd1);
        ticks(10, 1'b0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/f1_reaction_ctrl.md
# f1_reaction_ctrl

Sequencer for the F1 start-light game. It runs the five-step light build-up and the LFSR-randomised hold, then times the driver's reaction in milliseconds and flags false starts. It optionally keeps a best-time record. It sits between the 1 kHz tick generator, the LFSR and the LED/BCD display path, and replaces ad-hoc wiring of the light FSM, delay and LFSR enables with one controller.

## Interface
Parameters:
- STEP_MS, 500: milliseconds per light step.
- DELAY_UNIT_MS, 16: milliseconds per LFSR count of random hold.
- SAT_MS, 9999: reaction-count saturation value, the 4-digit display limit.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick_ms  in  1  one-clk strobe every 1 ms, synchronous to clk.
- trigger  in  1  start request, active-high level from the debounced key. Rising edge is used.
- react  in  1  reaction button, active-high level. Rising edge is used.
- lfsr_in  in  6  current LFSR value.
- lfsr_en  out  1  LFSR advance enable.
- ledr  out  10  start lights.
- react_ms  out  14  last valid reaction time in ms.
- best_ms  out  14  best reaction time (see Configuration).
- result_valid  out  1  one-clk pulse when react_ms updates.
- false_start  out  1  level: the last run ended in a false start.
- phase  out  3  state encoding: IDLE=0, LIGHTS=1, HOLD=2, TIMING=3, DONE=4, FOUL=5.

## Operation
- Edge detect: trigger and react each pass through a 1-flop delay. `rise = x & ~x_d`. Edge detection runs every clk, independent of tick_ms.
- Counters: ms_cnt is 10 bits and counts both light steps and the hold. step is 3 bits. hold_ms is 10 bits. react_cnt is 14 bits.
- IDLE:
  - Outputs: ledr=0, lfsr_en=1.
  - trigger rise → LIGHTS with ms_cnt=0, step=0.
- LIGHTS:
  - lfsr_en=1.
  - On tick_ms: if ms_cnt==STEP_MS-1, then ms_cnt=0, step+1, and ledr shifts left by 2 with 2'b11 fed in (0x003, 0x00F, 0x03F, 0x0FF, 0x3FF). Otherwise ms_cnt+1.
  - On the 5th step: latch hold_ms = max(lfsr_in,1)*DELAY_UNIT_MS, truncated to 10 bits. Set lfsr_en=0 from the next clk. Go to HOLD with ms_cnt=0.
- HOLD:
  - ledr=0x3FF.
  - On tick_ms: if ms_cnt==hold_ms-1, then ledr=0, react_cnt=0 → TIMING. Otherwise ms_cnt+1.
- TIMING:
  - ledr=0.
  - On tick_ms: react_cnt+1, saturating at SAT_MS.
  - On react rise: react_ms=react_cnt, pulse result_valid, → DONE.
- DONE:
  - lfsr_en=1. react_ms is held.
  - trigger rise → LIGHTS.
- FOUL:
  - Entered on react rise in LIGHTS or HOLD.
  - false_start=1, ledr=0x155, lfsr_en=1. react_ms is unchanged and no result_valid pulse.
  - trigger rise → LIGHTS and clears false_start.
- trigger rise is ignored in LIGHTS, HOLD and TIMING.
- react rise is ignored in IDLE and DONE.

## Timing
- Reset values:
  - phase=IDLE, ledr=0, react_ms=0, best_ms=SAT_MS.
  - result_valid=0, false_start=0, lfsr_en=1.
  - All counters 0.
- All outputs are registered. State changes take effect one clk after the qualifying edge or tick.
- result_valid asserts on the clk after the react rise is sampled.
- react rise and tick_ms in the same clk during TIMING: capture the pre-increment react_cnt.
- react rise and the final HOLD tick in the same clk: FOUL wins.
- react rise in the first clk of TIMING is valid and yields react_ms=0.
- Reaction resolution is ±1 ms. The first tick after entering a counting state counts as 1 ms elapsed.
- tick_ms is ignored in IDLE, DONE and FOUL.
- rst_n assertion mid-run returns every register to its reset value immediately. The block resumes in IDLE after deassertion; no pending edge survives reset.

## Configuration
- F1_BEST_TIME_EN defined:
  - After each result_valid, best_ms = min(best_ms, react_ms), updated in the same clk as the pulse.
  - A FOUL never updates best_ms.
- F1_BEST_TIME_EN undefined:
  - best_ms is tied to SAT_MS.
  - No compare or storage logic is built.

## Test plan
- Reset, then trigger rise with lfsr_in=5 and STEP_MS=500 → ledr reads 0x003, 0x00F, 0x03F, 0x0FF, 0x3FF, stepping every 500 ticks. Hold is 80 ticks, then ledr=0 and phase=TIMING.
- Press react 237 ticks into TIMING → react_ms=237 and a single result_valid pulse. With F1_BEST_TIME_EN, best_ms=237. A second run at 300 leaves best_ms=237.
- react rise during LIGHTS step 3 → phase=FOUL, ledr=0x155, false_start=1, react_ms unchanged. Next trigger clears false_start and restarts from 0x003.
- lfsr_in=0 at latch → hold is 16 ticks. No react for 12000 ticks in TIMING → react_ms=9999 on the later press.
- Same-clk react and tick in TIMING at react_cnt=42 → react_ms=42. Same-clk react and final HOLD tick → FOUL.
- Assert rst_n low during HOLD → ledr=0, phase=IDLE and best_ms=9999 immediately. Triggers pulsed in TIMING are ignored.
